// File: rtl/dmem_write_checker.sv
// Watches data-memory writes during a run and compares them to an ordered
// signature of expected (address, data) pairs, tolerating one scratch address.
module dmem_write_checker #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 11,
  parameter int P_NUM_CHECKS = 4,
  parameter int P_TIMEOUT    = 5000,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic                                 i_we,
  input  logic [P_ADDR_WIDTH-1:0]              i_addr,
  input  logic [P_DATA_WIDTH-1:0]              i_wdata,
  input  logic [P_NUM_CHECKS*P_ADDR_WIDTH-1:0] i_exp_addr,
  input  logic [P_NUM_CHECKS*P_DATA_WIDTH-1:0] i_exp_data,
  input  logic                                 i_ign_en,
  input  logic [P_ADDR_WIDTH-1:0]              i_ign_addr,
  output logic                                 o_busy,
  output logic                                 o_pass,
  output logic                                 o_fail,
  output logic [1:0]                           o_fail_code,
  output logic [P_CNT_WIDTH-1:0]               o_cycle_count,
  output logic [$clog2(P_NUM_CHECKS+1)-1:0]    o_match_idx,
  output logic [7:0]                           o_ign_count,
  output logic [P_ADDR_WIDTH-1:0]              o_last_addr,
  output logic [P_DATA_WIDTH-1:0]              o_last_data
);

  localparam int IW = $clog2(P_NUM_CHECKS+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(P_NUM_CHECKS-1);
  localparam logic [P_CNT_WIDTH-1:0] TMO_CNT = P_CNT_WIDTH'(P_TIMEOUT-1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL
  } state_e;

  state_e                    state_q, state_d;
  logic [P_CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [7:0]                ign_q, ign_d;
  logic [1:0]                code_q, code_d;
  logic [P_ADDR_WIDTH-1:0]   la_q, la_d;
  logic [P_DATA_WIDTH-1:0]   ld_q, ld_d;
  logic                      busy_q, pass_q, fail_q;

  logic [P_ADDR_WIDTH-1:0]   sel_a;
  logic [P_DATA_WIDTH-1:0]   sel_d;
  logic                      hit_a, hit_d, hit_ign;
  logic                      w_match, w_bad, w_ign, w_unexp;

  always_comb begin
    sel_a = '0;
    sel_d = '0;
    for (int k = 0; k < P_NUM_CHECKS; k++) begin
      if (idx_q == IW'(k)) begin
        sel_a = i_exp_addr[k*P_ADDR_WIDTH +: P_ADDR_WIDTH];
        sel_d = i_exp_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
      end
    end
  end

  assign hit_a   = (i_addr == sel_a);
  assign hit_d   = (i_wdata == sel_d);
  assign hit_ign = i_ign_en && (i_addr == i_ign_addr);
  assign w_match = i_we && hit_a && hit_d;
  assign w_bad   = i_we && hit_a && !hit_d;
  assign w_ign   = i_we && !hit_a && hit_ign;
  assign w_unexp = i_we && !hit_a && !hit_ign;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ign_d   = ign_q;
    code_d  = code_q;
    la_d    = la_q;
    ld_d    = ld_q;
    unique case (state_q)
      S_RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (i_we) begin
          la_d = i_addr;
          ld_d = i_wdata;
        end
        unique case (1'b1)
          w_match: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_d = S_PASS;
          end
          w_bad: begin
            state_d = S_FAIL;
            code_d  = 2'd2;
          end
          w_ign: ign_d = (&ign_q) ? ign_q : ign_q + 1'b1;
          w_unexp: begin
            state_d = S_FAIL;
            code_d  = 2'd1;
          end
          default: ;
        endcase
        // Completion or a write fault on the timeout edge takes precedence.
        if (state_d == S_RUN && cnt_d == TMO_CNT) begin
          state_d = S_FAIL;
          code_d  = 2'd3;
        end
      end
      default: begin
        if (i_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          idx_d   = '0;
          ign_d   = '0;
          code_d  = '0;
          la_d    = '0;
          ld_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ign_q   <= '0;
      code_q  <= '0;
      la_q    <= '0;
      ld_q    <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ign_q   <= ign_d;
      code_q  <= code_d;
      la_q    <= la_d;
      ld_q    <= ld_d;
      busy_q  <= (state_d == S_RUN);
      pass_q  <= (state_d == S_PASS);
      fail_q  <= (state_d == S_FAIL);
    end
  end

  assign o_busy        = busy_q;
  assign o_pass        = pass_q;
  assign o_fail        = fail_q;
  assign o_fail_code   = code_q;
  assign o_cycle_count = cnt_q;
  assign o_match_idx   = idx_q;
  assign o_ign_count   = ign_q;
  assign o_last_addr   = la_q;
  assign o_last_data   = ld_q;

endmodule
